// File: rtl/p1v_reset_seq.sv
// Reset sequencer: synchronises the reset pin, stretches reset, then releases
// the core and each cog in staggered order. Adds software reset and watchdog.
module p1v_reset_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned NUMCOGS        = 8,
    parameter int unsigned STAGGER        = 4,
    parameter int unsigned WDT_WIDTH      = 24
) (
    input  logic                 clk_cog,
    input  logic                 inp_resn,
    input  logic                 sw_reset,
    input  logic                 wdt_enable,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_timeout,
    output logic                 nres,
    output logic [NUMCOGS-1:0]   cog_resn,
    output logic                 reset_active,
    output logic [1:0]           reset_cause
);

    localparam int unsigned CNT_W  = $clog2(STRETCH_CYCLES) + 1;
    localparam int unsigned SPAN   = (NUMCOGS - 1) * STAGGER;
    localparam int unsigned SCNT_W = $clog2(SPAN + 1) + 1;
    localparam bit          DIRECT = (STAGGER == 0) || (NUMCOGS == 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES - 1);

    localparam logic [1:0] CAUSE_PIN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic [WDT_WIDTH-1:0]   wdt_cnt_q, wdt_d;
    logic                   nres_d;
    logic [NUMCOGS-1:0]     cog_d;
    logic                   active_d;
    logic [1:0]             cause_d;
    logic                   wdt_expire;

    // Pin deassertion synchroniser; assertion is asynchronous through the clear
    always_ff @(posedge clk_cog or negedge inp_resn) begin
        if (!inp_resn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Watchdog reaches its timeout in RUN without a kick on this cycle
    assign wdt_expire = (state_q == ST_RUN) && wdt_enable && !wdt_kick &&
                        (wdt_timeout != '0) && (wdt_cnt_q == wdt_timeout);

    // State, counters and all registered outputs
    always_ff @(posedge clk_cog or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            scnt_q       <= '0;
            wdt_cnt_q    <= '0;
            nres         <= 1'b0;
            cog_resn     <= '0;
            reset_active <= 1'b1;
            reset_cause  <= CAUSE_PIN;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scnt_q       <= scnt_d;
            wdt_cnt_q    <= wdt_d;
            nres         <= nres_d;
            cog_resn     <= cog_d;
            reset_active <= active_d;
            reset_cause  <= cause_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        wdt_d   = '0;
        nres_d  = nres;
        cog_d   = cog_resn;
        cause_d = reset_cause;

        case (state_q)
            ST_RESET: begin
                nres_d = 1'b0;
                cog_d  = '0;
                if (sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_STRETCH: begin
                if (sw_reset) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    nres_d = 1'b1;
                    scnt_d = '0;
                    if (DIRECT) begin
                        cog_d   = '1;
                        state_d = ST_RUN;
                    end else begin
                        cog_d   = NUMCOGS'(1);
                        state_d = ST_STAGGER;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STAGGER, ST_RUN: begin
                if (sw_reset || wdt_expire) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_LOAD;
                    nres_d  = 1'b0;
                    cog_d   = '0;
                    cause_d = sw_reset ? CAUSE_SW : CAUSE_WDT;
                end else if (state_q == ST_STAGGER) begin
                    scnt_d = scnt_q + SCNT_W'(1);
                    for (int unsigned i = 0; i < NUMCOGS; i++) begin
                        if (scnt_d == SCNT_W'(i * STAGGER)) begin
                            cog_d[i] = 1'b1;
                        end
                    end
                    if (scnt_d == SCNT_W'(SPAN)) begin
                        state_d = ST_RUN;
                    end
                end else if (wdt_enable && !wdt_kick && (wdt_timeout != '0)) begin
                    wdt_d = wdt_cnt_q + WDT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        active_d = (state_d != ST_RUN);
    end

endmodule

// File: tb/tb_p1v_reset_seq.sv
// Bench for p1v_reset_seq: three parameter sets share one stimulus stream and
// are checked every edge against an edge-arithmetic reference model.
module tb_p1v_reset_seq;

    logic        clk = 1'b0;
    logic        inp_resn;
    logic        sw_reset;
    logic        wdt_enable;
    logic        wdt_kick;
    logic [23:0] wdt_timeout;

    logic       nres0, ra0;
    logic [7:0] cog0;
    logic [1:0] cause0;
    logic       nres1, ra1;
    logic [3:0] cog1;
    logic [1:0] cause1;
    logic       nres2, ra2;
    logic [0:0] cog2;
    logic [1:0] cause2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    p1v_reset_seq dut0 (
        .clk_cog(clk), .inp_resn(inp_resn), .sw_reset(sw_reset),
        .wdt_enable(wdt_enable), .wdt_kick(wdt_kick), .wdt_timeout(wdt_timeout),
        .nres(nres0), .cog_resn(cog0), .reset_active(ra0), .reset_cause(cause0)
    );

    p1v_reset_seq #(.SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUMCOGS(4), .STAGGER(0)) dut1 (
        .clk_cog(clk), .inp_resn(inp_resn), .sw_reset(sw_reset),
        .wdt_enable(wdt_enable), .wdt_kick(wdt_kick), .wdt_timeout(wdt_timeout),
        .nres(nres1), .cog_resn(cog1), .reset_active(ra1), .reset_cause(cause1)
    );

    p1v_reset_seq #(.SYNC_STAGES(2), .STRETCH_CYCLES(3), .NUMCOGS(1), .STAGGER(4)) dut2 (
        .clk_cog(clk), .inp_resn(inp_resn), .sw_reset(sw_reset),
        .wdt_enable(wdt_enable), .wdt_kick(wdt_kick), .wdt_timeout(wdt_timeout),
        .nres(nres2), .cog_resn(cog2), .reset_active(ra2), .reset_cause(cause2)
    );

    // Parameters of each instance, for the model
    function automatic int p_sync(int k);
        return (k == 1) ? 3 : 2;
    endfunction
    function automatic int p_str(int k);
        return (k == 0) ? 16 : ((k == 1) ? 1 : 3);
    endfunction
    function automatic int p_nc(int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
    endfunction
    function automatic int p_stg(int k);
        return (k == 1) ? 0 : 4;
    endfunction

    // Model: edges counted from pin release; a reset is described by the edge
    // that enters STRETCH (m_entry), nres release edge (m_rel) and RUN edge (m_run).
    int          m_e     [3];
    int          m_entry [3];
    int          m_rel   [3];
    int          m_run   [3];
    logic [23:0] m_wcnt  [3];
    logic [1:0]  m_cause [3];
    bit          fresh   [3];

    function automatic void model_reset(int k);
        m_e[k]     = 0;
        m_entry[k] = p_sync(k) + 1;
        m_rel[k]   = m_entry[k] + p_str(k);
        m_run[k]   = m_rel[k] + (p_nc(k) - 1) * p_stg(k);
        m_wcnt[k]  = '0;
        m_cause[k] = 2'b01;
        fresh[k]   = 1'b1;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            int p;
            bit in_reset, in_stretch, in_run, live, expire;
            if (!inp_resn) begin
                model_reset(k);
            end else begin
                p          = m_e[k];
                m_e[k]     = p + 1;
                in_reset   = (p < m_entry[k]);
                in_stretch = !in_reset && (p < m_rel[k]);
                in_run     = (p >= m_run[k]);
                live       = !in_reset && !in_stretch;
                expire     = in_run && wdt_enable && (wdt_timeout != 0) &&
                             (m_wcnt[k] == wdt_timeout) && !wdt_kick;
                if (in_run && wdt_enable && !wdt_kick && (wdt_timeout != 0) && !sw_reset && !expire)
                    m_wcnt[k] = m_wcnt[k] + 24'd1;
                else
                    m_wcnt[k] = '0;
                if (in_stretch && sw_reset) begin
                    m_rel[k] = m_e[k] + p_str(k);
                    m_run[k] = m_rel[k] + (p_nc(k) - 1) * p_stg(k);
                    fresh[k] = 1'b0;
                end else if (live && (sw_reset || expire)) begin
                    m_entry[k] = m_e[k];
                    m_rel[k]   = m_e[k] + p_str(k);
                    m_run[k]   = m_rel[k] + (p_nc(k) - 1) * p_stg(k);
                    m_cause[k] = sw_reset ? 2'b10 : 2'b11;
                    fresh[k]   = 1'b0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ec, oc;
            logic       on, ora;
            logic [1:0] ocz;
            ec = '0;
            for (int i = 0; i < p_nc(k); i++)
                if (m_e[k] >= m_rel[k] + i * p_stg(k)) ec = ec | (8'(1) << i);
            case (k)
                0:       begin on = nres0; oc = cog0;      ora = ra0; ocz = cause0; end
                1:       begin on = nres1; oc = 8'(cog1);  ora = ra1; ocz = cause1; end
                default: begin on = nres2; oc = 8'(cog2);  ora = ra2; ocz = cause2; end
            endcase
            chk($sformatf("d%0d_nres@e%0d", k, m_e[k]), 8'(on), 8'(m_e[k] >= m_rel[k]));
            chk($sformatf("d%0d_cog@e%0d", k, m_e[k]), oc, ec);
            chk($sformatf("d%0d_active@e%0d", k, m_e[k]), 8'(ora), 8'(m_e[k] < m_run[k]));
            chk($sformatf("d%0d_cause@e%0d", k, m_e[k]), 8'(ocz), 8'(m_cause[k]));
        end
        // Release edges of an undisturbed pin sequence
        if (fresh[0]) begin
            if (m_e[0] == 18) chk("d0_pin_nres_e18", 8'(nres0), 8'h00);
            if (m_e[0] == 19) chk("d0_pin_cog_e19", {7'(0), nres0} | cog0, 8'h01);
            if (m_e[0] == 23) chk("d0_pin_cog_e23", cog0, 8'h03);
            if (m_e[0] == 46) chk("d0_pin_active_e46", 8'(ra0), 8'h01);
            if (m_e[0] == 47) chk("d0_pin_cog_e47", {cog0[6:0], ra0}, 8'hFE);
        end
        if (fresh[1]) begin
            if (m_e[1] == 4) chk("d1_pin_nres_e4", 8'(nres1), 8'h00);
            if (m_e[1] == 5) chk("d1_pin_all_e5", {2'(0), nres1, ra1, cog1}, 8'h2F);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Short pin pulse between edges; called just after step()
    task automatic pin_pulse();
        #2 inp_resn = 1'b0;
        for (int k = 0; k < 3; k++) model_reset(k);
        #1 check_all();
        #2 inp_resn = 1'b1;
    endtask

    initial begin
        int  hits;
        bit  hit;

        inp_resn    = 1'b1;
        sw_reset    = 1'b0;
        wdt_enable  = 1'b0;
        wdt_kick    = 1'b0;
        wdt_timeout = 24'd0;
        for (int k = 0; k < 3; k++) model_reset(k);

        // Power-on reset and first release sequence
        #2 inp_resn = 1'b0;
        #1 check_all();
        steps(3);
        #4 inp_resn = 1'b1;
        steps(60);

        // Pin pulse mid-RUN
        pin_pulse();
        steps(55);

        // Software reset held for five edges
        sw_reset = 1'b1;
        steps(5);
        sw_reset = 1'b0;
        steps(60);

        // Watchdog expiry without kicks
        wdt_enable  = 1'b1;
        wdt_timeout = 24'd10;
        steps(80);

        // Regular kicks every 8 edges keep the system alive
        for (int i = 0; i < 1000; i++) begin
            wdt_kick = ((i % 8) == 7);
            step();
        end
        wdt_kick = 1'b0;

        // Kick exactly on the expiry cycle
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            wdt_kick = (m_wcnt[0] == wdt_timeout);
            if (wdt_kick) hits++;
            step();
        end
        wdt_kick = 1'b0;
        chk("kick_on_expiry_hits", 8'(hits > 5), 8'h01);
        chk("kick_on_expiry_nres", 8'(nres0), 8'h01);

        // Software reset coincident with expiry
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_wcnt[0] == wdt_timeout) begin
                sw_reset = 1'b1;
                hit      = 1'b1;
            end
            step();
            sw_reset = 1'b0;
        end
        chk("sw_and_wdt_seen", 8'(hit), 8'h01);
        chk("sw_and_wdt_cause", 8'(cause0), 8'h02);
        steps(60);

        // Zero timeout never resets
        wdt_timeout = 24'd0;
        steps(200);

        // Pin reset after three cogs have been released
        pin_pulse();
        for (int i = 0; i < 60 && m_e[0] != 27; i++) step();
        chk("stagger_three_cogs", cog0, 8'h07);
        pin_pulse();
        chk("stagger_pin_cog", cog0, 8'h00);
        steps(55);

        // Randomised mix of all inputs
        wdt_timeout = 24'd12;
        for (int i = 0; i < 800; i++) begin
            sw_reset   = ($urandom_range(0, 39) == 0);
            wdt_kick   = ($urandom_range(0, 14) == 0);
            wdt_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) wdt_timeout = 24'($urandom_range(3, 20));
            step();
            if ($urandom_range(0, 299) == 0) pin_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
